router_ingress: RTL and testbench
=================================

Name: router_ingress

Overview:
- Packet ingress controller in front of the three per-port router FIFOs (9-bit entries: lfd_state plus 8-bit data).
- Accepts a byte stream with a valid/ready handshake and parses each packet: header, then payload, then parity.
- Steers header and payload into the addressed FIFO and drives lfd_state on the header write.
- Checks packet parity, drops packets with an invalid address, and applies per-FIFO backpressure.

Parameters:
- DW, 8, data byte width (header layout below assumes 8).
- NPORT, 3, number of destination FIFOs; address value NPORT and above is invalid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  byte accepted on a cycle where in_valid && in_ready.
- fifo_full  in  3  full flags from FIFO 0..2.
- fifo_din  out  8  data to FIFOs, shared bus.
- fifo_wr_en  out  3  one-hot write enable, at most one bit high.
- lfd_state  out  1  high only on a header write.
- pkt_done  out  1  one-cycle pulse when the parity byte is accepted.
- parity_err  out  1  one-cycle pulse with pkt_done on parity mismatch.
- addr_err  out  1  one-cycle pulse when an invalid-address header is accepted.
- pkt_count  out  8  count of pkt_done pulses, wraps 255 -> 0.

Behaviour:
- Packet format:
  - Header byte: [1:0] = dest addr, [7:2] = payload length L (0..63).
  - Then L payload bytes.
  - Then one parity byte equal to the XOR of the header and all payload bytes.
- Reset (async, while rst=1):
  - State IDLE; in_ready=0; fifo_wr_en=0; lfd_state=0; fifo_din=0.
  - pkt_done, parity_err, addr_err = 0; pkt_count=0; internal header, length and parity registers = 0.
  - Reset mid-packet abandons the packet; no further writes for it.
- IDLE:
  - in_ready=1. On accept: latch addr and L, set parity accumulator to the header byte.
  - Next state: HDR_WR if addr < NPORT; otherwise DROP, with a registered addr_err pulse on the next cycle.
- HDR_WR:
  - in_ready=0.
  - While fifo_full[addr]=1: hold, no write.
  - When not full: fifo_wr_en[addr]=1, lfd_state=1, fifo_din = latched header (combinational in this cycle).
  - Next state: PAYLOAD if L>0, else PARITY.
- PAYLOAD:
  - in_ready = !fifo_full[addr].
  - Accepted byte passes through in the same cycle: fifo_din=in_data, fifo_wr_en[addr]=1, lfd_state=0.
  - Accumulator ^= byte; remaining count decrements. After the L-th byte, go to PARITY.
  - When fifo_full rises, in_ready drops in that cycle; no byte is lost or duplicated.
- PARITY:
  - in_ready=1. The byte is accepted and not written to any FIFO.
  - Registered one-cycle pulses next cycle: pkt_done=1, parity_err = (byte != accumulator); pkt_count increments.
  - Next state IDLE.
- DROP:
  - in_ready=1. Consume L payload bytes plus the parity byte with no writes, then go to IDLE.
  - No pkt_done, no pkt_count change.
- Stall: in_valid=0 in any state holds state and counters.
- Back-to-back packets: a header can be accepted on the cycle after the parity byte (IDLE reached). Throughput is L+3 cycles per packet with no stalls.
- Invariants:
  - fifo_wr_en is never set on a full FIFO.
  - lfd_state=1 only when fifo_wr_en≠0.
  - Never more than one fifo_wr_en bit high.

Test Plan:
- Reset then packet: header 0x0D (addr 1, L=3), payload 0xA5 0x3C 0xFF, parity 0x0D^0xA5^0x3C^0xFF=0x6B.
  - Required: FIFO1 writes 0x0D with lfd_state=1, then 0xA5, 0x3C, 0xFF with lfd_state=0.
  - Required: pkt_done pulse, parity_err=0, pkt_count=1.
- Same packet with parity 0x6A -> identical writes; pkt_done=1 and parity_err=1 in the same cycle.
- Header 0x07 (addr 3, L=1), payload 0x11, parity 0x16 -> addr_err pulse; zero FIFO writes; 3 bytes consumed; pkt_count unchanged.
- Header 0x08 (addr 0, L=2) with fifo_full[0] held high for 4 cycles during HDR_WR, then again after the first payload byte:
  - Required: in_ready=0 and no writes while full.
  - Required: exactly 3 writes total to FIFO0; no lost or duplicate bytes.
- Header 0x02 (addr 2, L=0), parity 0x02 -> single header write to FIFO2, then pkt_done. Immediately followed by a second packet: its header is accepted the next cycle.
- rst asserted mid-payload of an addr-0, L=5 packet after 2 bytes:
  - Required: outputs 0 immediately (async) and pkt_count=0.
  - Required: after release, in IDLE, and the next header starts a fresh packet.

Source files
------------

// File: rtl/router_ingress_if.sv
// Byte-stream ingress and per-port FIFO write bus for router_ingress.
// Latency: none (signal bundle only).
// Backpressure: in_ready from the controller, fifo_full from each FIFO.
interface router_ingress_if #(
  parameter int DW    = 8,
  parameter int NPORT = 3
);
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [NPORT-1:0] fifo_full;
  logic [DW-1:0]    fifo_din;
  logic [NPORT-1:0] fifo_wr_en;
  logic             lfd_state;
  logic             pkt_done;
  logic             parity_err;
  logic             addr_err;
  logic [7:0]       pkt_count;

  // Ingress controller side: consumes the stream, drives the FIFO bus.
  modport slave (
    input  in_valid, in_data, fifo_full,
    output in_ready, fifo_din, fifo_wr_en, lfd_state,
    output pkt_done, parity_err, addr_err, pkt_count
  );

  // Upstream source and FIFO side.
  modport master (
    output in_valid, in_data, fifo_full,
    input  in_ready, fifo_din, fifo_wr_en, lfd_state,
    input  pkt_done, parity_err, addr_err, pkt_count
  );
endinterface

// File: rtl/router_ingress.sv
// Parses header/payload/parity packets and steers them into one of NPORT FIFOs.
// Latency: header written one cycle after accept; payload bytes pass through combinationally.
// Backpressure: in_ready drops while the addressed FIFO is full; the header write waits on it too.
module router_ingress #(
  parameter int DW    = 8,
  parameter int NPORT = 3
) (
  input  logic           clk,
  input  logic           rst,
  router_ingress_if.slave bus
);
  localparam int AW = 2;
  localparam int LW = DW - AW;
  localparam logic [AW:0] NPORT_L = (AW+1)'(NPORT);

  typedef enum logic [2:0] {IDLE, HDR_WR, PAYLOAD, PARITY, DROP} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   remain;
  logic [DW-1:0]   hdr;
  logic [DW-1:0]   acc;
  logic            full_sel;
  logic            hdr_ok;
  logic            ready;
  logic            accept;
  logic            wr;
  logic            lfd;
  logic [DW-1:0]   din;
  logic            pkt_done_q, parity_err_q, addr_err_q;
  logic [7:0]      pkt_count_q;

  assign hdr_ok = {1'b0, bus.in_data[AW-1:0]} < NPORT_L;

  // Full flag of the FIFO addressed by the latched header.
  always_comb begin
    full_sel = 1'b0;
    for (int i = 0; i < NPORT; i++)
      if (addr == AW'(i)) full_sel = bus.fifo_full[i];
  end

  // Next-state, handshake and FIFO write decode.
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    wr      = 1'b0;
    lfd     = 1'b0;
    din     = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_n = hdr_ok ? HDR_WR : DROP;
      end
      HDR_WR: begin
        if (!full_sel) begin
          wr      = 1'b1;
          lfd     = 1'b1;
          din     = hdr;
          state_n = (remain != '0) ? PAYLOAD : PARITY;
        end
      end
      PAYLOAD: begin
        ready = !full_sel;
        if (bus.in_valid && !full_sel) begin
          wr  = 1'b1;
          din = bus.in_data;
          if (remain == LW'(1)) state_n = PARITY;
        end
      end
      PARITY: begin
        ready = 1'b1;
        if (bus.in_valid) state_n = IDLE;
      end
      DROP: begin
        ready = 1'b1;
        if (bus.in_valid && remain == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    accept = bus.in_valid && ready;
  end

  // One-hot write enable; only ever the latched (valid) address.
  always_comb begin
    bus.fifo_wr_en = '0;
    for (int i = 0; i < NPORT; i++)
      bus.fifo_wr_en[i] = wr && (addr == AW'(i));
  end

  // in_ready is forced low while reset is held, not just after the next edge.
  assign bus.in_ready   = ready && !rst;
  assign bus.fifo_din   = din;
  assign bus.lfd_state  = lfd;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.pkt_count  = pkt_count_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Header latch, remaining-length counter, parity accumulator and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr         <= '0;
      remain       <= '0;
      hdr          <= '0;
      acc          <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          hdr        <= bus.in_data;
          addr       <= bus.in_data[AW-1:0];
          remain     <= bus.in_data[DW-1:AW];
          acc        <= bus.in_data;
          addr_err_q <= !hdr_ok;
        end
        PAYLOAD: if (accept) begin
          acc    <= acc ^ bus.in_data;
          remain <= remain - 1'b1;
        end
        PARITY: if (accept) begin
          pkt_done_q   <= 1'b1;
          parity_err_q <= (bus.in_data != acc);
          pkt_count_q  <= pkt_count_q + 8'd1;
        end
        DROP: if (accept && remain != '0) remain <= remain - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_router_ingress.sv
// Directed vector bench for router_ingress: per-cycle stimulus with expected outputs.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Registered pulses (pkt_done/parity_err/addr_err) are expected in the cycle after the accept.
module tb_router_ingress;
  logic clk;
  logic rst;

  router_ingress_if #(.DW(8), .NPORT(3)) bus ();

  router_ingress #(.DW(8), .NPORT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic [2:0] full;
    logic       rdy;
    logic [2:0] wr;
    logic [7:0] din;
    logic       lfd;
    logic       done;
    logic       perr;
    logic       aerr;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic vld, logic [7:0] dat, logic [2:0] full, logic rdy,
                              logic [2:0] wr, logic [7:0] din, logic lfd, logic done,
                              logic perr, logic aerr, logic [7:0] cnt);
    vec_t v;
    v.vld = vld; v.dat = dat; v.full = full; v.rdy = rdy; v.wr = wr; v.din = din;
    v.lfd = lfd; v.done = done; v.perr = perr; v.aerr = aerr; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t v, input int idx);
    chk("in_ready",   idx, 8'(bus.in_ready),   8'(v.rdy));
    chk("fifo_wr_en", idx, 8'(bus.fifo_wr_en), 8'(v.wr));
    if (v.wr != 3'b000) chk("fifo_din", idx, bus.fifo_din, v.din);
    chk("lfd_state",  idx, 8'(bus.lfd_state),  8'(v.lfd));
    chk("pkt_done",   idx, 8'(bus.pkt_done),   8'(v.done));
    chk("parity_err", idx, 8'(bus.parity_err), 8'(v.perr));
    chk("addr_err",   idx, 8'(bus.addr_err),   8'(v.aerr));
    chk("pkt_count",  idx, bus.pkt_count,      v.cnt);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    bus.in_valid  = v.vld;
    bus.in_data   = v.dat;
    bus.fifo_full = v.full;
    @(negedge clk);
    n_vec++;
    check_outs(v, idx);
  endtask

  initial begin
    // Packet addr1 L3 good parity, with a stall and an unrelated full flag.
    tbl.push_back(mk(1, 8'h0D, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'hA5, 3'b001, 1, 3'b010, 8'hA5, 0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'h3C, 3'b000, 1, 3'b010, 8'h3C, 0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'hFF, 3'b000, 1, 3'b010, 8'hFF, 0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 8'h6B, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0));
    // Back-to-back: same packet with bad parity 0x6A.
    tbl.push_back(mk(1, 8'h0D, 3'b000, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'd1));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'hA5, 3'b000, 1, 3'b010, 8'hA5, 0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h3C, 3'b000, 1, 3'b010, 8'h3C, 0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'hFF, 3'b000, 1, 3'b010, 8'hFF, 0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 8'h6A, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd1));
    // Invalid address 3, L1: three bytes consumed, no writes, addr_err.
    tbl.push_back(mk(1, 8'h07, 3'b000, 1, 3'b000, 8'h00, 0, 1, 1, 0, 8'd2));
    tbl.push_back(mk(1, 8'h11, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 8'h16, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd2));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd2));
    // addr2 L0, then next header accepted the cycle after parity.
    tbl.push_back(mk(1, 8'h02, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd2));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 3'b100, 8'h02, 1, 0, 0, 0, 8'd2));
    tbl.push_back(mk(1, 8'h02, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd2));
    tbl.push_back(mk(1, 8'h0D, 3'b000, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'd3));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 8'hA5, 3'b000, 1, 3'b010, 8'hA5, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 8'h3C, 3'b000, 1, 3'b010, 8'h3C, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 8'hFF, 3'b000, 1, 3'b010, 8'hFF, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(1, 8'h6B, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd3));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'd4));
    // addr0 L2 with FIFO0 full during header write and after first payload byte.
    tbl.push_back(mk(1, 8'h08, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd4));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 8'h00, 3'b001, 0, 3'b000, 8'h00, 0, 0, 0, 0, 8'd4));
    tbl.push_back(mk(0, 8'h00, 3'b000, 0, 3'b001, 8'h08, 1, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 8'h55, 3'b000, 1, 3'b001, 8'h55, 0, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 8'hAA, 3'b001, 0, 3'b000, 8'h00, 0, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 8'hAA, 3'b001, 0, 3'b000, 8'h00, 0, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 8'hAA, 3'b000, 1, 3'b001, 8'hAA, 0, 0, 0, 0, 8'd4));
    tbl.push_back(mk(1, 8'hF7, 3'b001, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd4));
    tbl.push_back(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'd5));

    // Reset state.
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.fifo_full = 3'b000;
    #2;
    n_vec++;
    check_outs(mk(0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0), 1000);
    chk("fifo_din_rst", 1000, bus.fifo_din, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset in the middle of an addr0 L5 packet after two payload bytes.
    apply(mk(1, 8'h14, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd5), 2000);
    apply(mk(0, 8'h00, 3'b000, 0, 3'b001, 8'h14, 1, 0, 0, 0, 8'd5), 2001);
    apply(mk(1, 8'h01, 3'b000, 1, 3'b001, 8'h01, 0, 0, 0, 0, 8'd5), 2002);
    apply(mk(1, 8'h02, 3'b000, 1, 3'b001, 8'h02, 0, 0, 0, 0, 8'd5), 2003);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    #1;
    chk("third_byte_wr", 2004, 8'(bus.fifo_wr_en), 8'h01);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    check_outs(mk(1, 8'h03, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0), 2005);
    chk("fifo_din_rst", 2005, bus.fifo_din, 8'h00);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1, 8'h0D, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0), 2010);
    apply(mk(0, 8'h00, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0, 8'd0), 2011);
    apply(mk(1, 8'hA5, 3'b000, 1, 3'b010, 8'hA5, 0, 0, 0, 0, 8'd0), 2012);
    apply(mk(1, 8'h3C, 3'b000, 1, 3'b010, 8'h3C, 0, 0, 0, 0, 8'd0), 2013);
    apply(mk(1, 8'hFF, 3'b000, 1, 3'b010, 8'hFF, 0, 0, 0, 0, 8'd0), 2014);
    apply(mk(1, 8'h6B, 3'b000, 1, 3'b000, 8'h00, 0, 0, 0, 0, 8'd0), 2015);
    apply(mk(0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 0, 1, 0, 0, 8'd1), 2016);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
